// File: rtl/i2s_clock_gen.sv
// I2S / left-justified / TDM bit and frame clock generator.
// Runtime divider and format, re-latched only on frame boundaries.
module i2s_clock_gen #(
    parameter  int DIV_WIDTH  = 8,
    parameter  int SLOT_BITS  = 32,
    parameter  int NUM_SLOTS  = 2,
    localparam int FRAME_BITS = SLOT_BITS * NUM_SLOTS,
    localparam int BW         = $clog2(FRAME_BITS),
    localparam int SW         = $clog2(NUM_SLOTS)
) (
    input  logic                 sys_clk,
    input  logic                 reset_n,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [1:0]           mode_i,
    output logic                 sclk_o,
    output logic                 lrclk_o,
    output logic                 sclk_rise_o,
    output logic                 sclk_fall_o,
    output logic [BW-1:0]        bit_cnt_o,
    output logic [SW-1:0]        slot_o,
    output logic                 running_o,
    output logic                 locked_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DIV_WIDTH-1:0] D_ONE  = DIV_WIDTH'(1);
    localparam logic [BW-1:0]        LAST   = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0]        HALF   = BW'(FRAME_BITS / 2);
    localparam logic [BW-1:0]        I2S_LO = BW'(FRAME_BITS / 2 - 1);
    localparam logic [BW-1:0]        I2S_HI = BW'(FRAME_BITS - 2);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DIV_WIDTH-1:0] r_hcnt;
    logic [DIV_WIDTH-1:0] r_div;
    logic [1:0]           r_mode;
    logic                 r_sclk;
    logic                 r_lrclk;
    logic                 r_rise;
    logic                 r_fall;
    logic                 r_locked;
    logic [BW-1:0]        r_bit_cnt;

    logic [DIV_WIDTH-1:0] w_div_eff;
    logic [BW-1:0]        w_bit_nxt;
    logic                 w_tick;
    logic                 w_fall;
    logic                 w_wrap;
    logic                 w_cfg_same;
    logic                 w_lr_nxt;

    assign w_div_eff  = (div_i == '0) ? D_ONE : div_i;
    assign w_tick     = (r_state == S_RUN) && (r_hcnt == r_div - D_ONE);
    assign w_fall     = w_tick && r_sclk;
    assign w_wrap     = w_fall && (r_bit_cnt == LAST);
    assign w_bit_nxt  = (r_bit_cnt == LAST) ? '0 : r_bit_cnt + BW'(1);
    assign w_cfg_same = (w_div_eff == r_div) && (mode_i == r_mode);

    // Frame clock level for the bit position about to be entered
    always_comb begin
        w_lr_nxt = 1'b0;
        case (r_mode)
            2'b01:   w_lr_nxt = (w_bit_nxt >= HALF);
            2'b10:   w_lr_nxt = (w_bit_nxt == LAST);
            default: w_lr_nxt = (w_bit_nxt >= I2S_LO) && (w_bit_nxt <= I2S_HI);
        endcase
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Start on request, stop only at the end of a whole frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (enable_i) w_state_nxt = S_RUN;
            S_RUN:   if (w_wrap && !enable_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Divider, bit clock, bit counter, frame clock and lock tracking
    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            r_hcnt    <= '0;
            r_div     <= D_ONE;
            r_mode    <= 2'b00;
            r_sclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_locked  <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_state == S_IDLE) begin
                r_sclk   <= 1'b0;
                r_lrclk  <= 1'b0;
                r_locked <= 1'b0;
                if (enable_i) begin
                    r_div     <= w_div_eff;
                    r_mode    <= mode_i;
                    r_hcnt    <= '0;
                    r_bit_cnt <= '0;
                end
            end else begin
                if (w_tick) begin
                    r_hcnt <= '0;
                    r_sclk <= ~r_sclk;
                    r_rise <= ~r_sclk;
                    r_fall <= r_sclk;
                end else begin
                    r_hcnt <= r_hcnt + D_ONE;
                end
                if (w_fall) begin
                    r_bit_cnt <= w_bit_nxt;
                    r_lrclk   <= w_lr_nxt;
                end
                if (w_wrap) begin
                    if (!enable_i) begin
                        r_lrclk  <= 1'b0;
                        r_locked <= 1'b0;
                    end else begin
                        r_div    <= w_div_eff;
                        r_mode   <= mode_i;
                        r_locked <= w_cfg_same;
                    end
                end
            end
        end
    end

    // Drive ports from the registered state
    always_comb begin
        running_o   = (r_state == S_RUN);
        sclk_o      = r_sclk;
        lrclk_o     = r_lrclk;
        sclk_rise_o = r_rise;
        sclk_fall_o = r_fall;
        bit_cnt_o   = r_bit_cnt;
        slot_o      = r_bit_cnt[BW-1 -: SW];
        locked_o    = r_locked;
    end

endmodule

// File: tb/tb_i2s_clock_gen.sv
// Bench for i2s_clock_gen: two instances (2 and 8 slots of 4 bits)
// driven together and compared each cycle with a time-based model.
module tb_i2s_clock_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div;
    logic [1:0] mode;

    always #5 clk = ~clk;

    logic       a_sclk, a_lr, a_rise, a_fall, a_run, a_lock;
    logic [2:0] a_bit;
    logic [0:0] a_slot;
    logic       b_sclk, b_lr, b_rise, b_fall, b_run, b_lock;
    logic [4:0] b_bit;
    logic [2:0] b_slot;

    i2s_clock_gen #(.DIV_WIDTH(8), .SLOT_BITS(4), .NUM_SLOTS(2)) u_a (
        .sys_clk(clk), .reset_n(rst_n), .enable_i(en), .div_i(div),
        .mode_i(mode), .sclk_o(a_sclk), .lrclk_o(a_lr),
        .sclk_rise_o(a_rise), .sclk_fall_o(a_fall), .bit_cnt_o(a_bit),
        .slot_o(a_slot), .running_o(a_run), .locked_o(a_lock)
    );

    i2s_clock_gen #(.DIV_WIDTH(8), .SLOT_BITS(4), .NUM_SLOTS(8)) u_b (
        .sys_clk(clk), .reset_n(rst_n), .enable_i(en), .div_i(div),
        .mode_i(mode), .sclk_o(b_sclk), .lrclk_o(b_lr),
        .sclk_rise_o(b_rise), .sclk_fall_o(b_fall), .bit_cnt_o(b_bit),
        .slot_o(b_slot), .running_o(b_run), .locked_o(b_lock)
    );

    wire [15:0] got_a = {a_sclk, a_lr, a_rise, a_fall, a_run, a_lock,
                         3'b000, a_slot, 3'b000, a_bit};
    wire [15:0] got_b = {b_sclk, b_lr, b_rise, b_fall, b_run, b_lock,
                         1'b0, b_slot, 1'b0, b_bit};

    int tests = 0;
    int fails = 0;

    // s = cycles since the current frame started; e0 = a frame just ended
    typedef struct {
        bit run;
        int d;
        int mode;
        bit lock;
        int s;
        bit e0;
    } mdl_t;
    mdl_t m[2];

    function automatic void mstep(int i);
        int fb = (i == 0) ? 8 : 32;
        int de = (div == 8'd0) ? 1 : int'(div);
        m[i].e0 = 1'b0;
        if (!rst_n) begin
            m[i].run = 0; m[i].d = 1; m[i].mode = 0;
            m[i].lock = 0; m[i].s = 0;
        end else if (!m[i].run) begin
            if (en) begin
                m[i].run = 1; m[i].d = de;
                m[i].mode = int'(mode); m[i].s = 0;
            end
        end else begin
            m[i].s++;
            if (m[i].s == 2 * m[i].d * fb) begin
                m[i].s  = 0;
                m[i].e0 = 1'b1;
                if (!en) begin
                    m[i].run  = 0;
                    m[i].lock = 0;
                end else begin
                    m[i].lock = (de == m[i].d) && (int'(mode) == m[i].mode);
                    m[i].d    = de;
                    m[i].mode = int'(mode);
                end
            end
        end
    endfunction

    function automatic logic [15:0] mexp(int i);
        int   fb = (i == 0) ? 8 : 32;
        int   d  = m[i].d;
        int   s  = m[i].s;
        int   b;
        logic sc, lr, ri, fa;
        if (!m[i].run) return {3'b000, m[i].e0, 2'b00, 10'd0};
        sc = ((s / d) % 2) == 1;
        b  = (s / (2 * d)) % fb;
        ri = (s > 0) && (s % d == 0) && sc;
        fa = m[i].e0 || ((s > 0) && (s % d == 0) && !sc);
        case (m[i].mode)
            1:       lr = (b >= fb / 2);
            2:       lr = (b == fb - 1);
            default: lr = (b >= fb / 2 - 1) && (b <= fb - 2);
        endcase
        return {sc, lr, ri, fa, 1'b1, m[i].lock, 4'(b / 4), 6'(b)};
    endfunction

    task automatic tick();
        @(posedge clk);
        mstep(0);
        mstep(1);
        #1;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        en    = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; div = 8'd2; mode = 2'b01;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (got_a !== 16'h0) begin
                fails++;
                $display("FAIL reset_a got=%h exp=%h", got_a, 16'h0);
            end
            tests++;
            if (got_b !== 16'h0) begin
                fails++;
                $display("FAIL reset_b got=%h exp=%h", got_b, 16'h0);
            end
        end
        rst_n = 1'b1; en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if (got_a !== mexp(0) || got_b !== mexp(1)) begin
                fails++;
                $display("FAIL idle got=%h/%h exp=%h/%h",
                         got_a, got_b, mexp(0), mexp(1));
            end
        end
    endtask

    task automatic test_lj();
        int nr = 0;
        int nf = 0;
        restart();
        div = 8'd2; mode = 2'b01; en = 1'b1;
        tick();
        for (int c = 1; c <= 104; c++) begin
            tick();
            if (c <= 32 && a_rise) nr++;
            if (c <= 32 && a_fall) nf++;
            tests++;
            if (got_a !== mexp(0) || got_b !== mexp(1)) begin
                fails++;
                $display("FAIL lj c=%0d got=%h/%h exp=%h/%h",
                         c, got_a, got_b, mexp(0), mexp(1));
            end
        end
        tests++;
        if (nr !== 8 || nf !== 8) begin
            fails++;
            $display("FAIL lj_edges rises=%0d falls=%0d exp=8/8", nr, nf);
        end
    endtask

    task automatic test_i2s();
        restart();
        div = 8'd2; mode = 2'b00; en = 1'b1;
        for (int c = 0; c < 140; c++) begin
            tick();
            tests++;
            if (got_a !== mexp(0) || got_b !== mexp(1)) begin
                fails++;
                $display("FAIL i2s c=%0d got=%h/%h exp=%h/%h",
                         c, got_a, got_b, mexp(0), mexp(1));
            end
        end
    endtask

    task automatic test_tdm();
        int np = 0;
        restart();
        div = 8'd1; mode = 2'b10; en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (b_lr) np++;
            tests++;
            if (got_a !== mexp(0) || got_b !== mexp(1)) begin
                fails++;
                $display("FAIL tdm c=%0d got=%h/%h exp=%h/%h",
                         c, got_a, got_b, mexp(0), mexp(1));
            end
        end
        tests++;
        if (np !== 6) begin
            fails++;
            $display("FAIL tdm_sync lrclk_cycles=%0d exp=6", np);
        end
    endtask

    task automatic test_div_change();
        restart();
        div = 8'd2; mode = 2'b01; en = 1'b1;
        for (int c = 0; c < 260; c++) begin
            if (c == 41) div = 8'd3;
            tick();
            tests++;
            if (got_a !== mexp(0) || got_b !== mexp(1)) begin
                fails++;
                $display("FAIL divchg c=%0d got=%h/%h exp=%h/%h",
                         c, got_a, got_b, mexp(0), mexp(1));
            end
        end
    endtask

    task automatic test_stop();
        restart();
        div = 8'd2; mode = 2'b01; en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (c == 9) en = 1'b0;
            if (c == 150) begin
                div = 8'd0;
                en  = 1'b1;
            end
            tick();
            tests++;
            if (got_a !== mexp(0) || got_b !== mexp(1)) begin
                fails++;
                $display("FAIL stop c=%0d got=%h/%h exp=%h/%h",
                         c, got_a, got_b, mexp(0), mexp(1));
            end
        end
    endtask

    task automatic test_reset_mid();
        restart();
        div = 8'd2; mode = 2'b01; en = 1'b1;
        for (int c = 0; c < 120; c++) begin
            rst_n = (c != 21);
            tick();
            tests++;
            if (got_a !== mexp(0) || got_b !== mexp(1)) begin
                fails++;
                $display("FAIL rstmid c=%0d got=%h/%h exp=%h/%h",
                         c, got_a, got_b, mexp(0), mexp(1));
            end
        end
    endtask

    task automatic test_random();
        restart();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) en = ~en;
            if ($urandom_range(0, 99) < 4) div = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 4) mode = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
            tests++;
            if (got_a !== mexp(0) || got_b !== mexp(1)) begin
                fails++;
                $display("FAIL rand c=%0d got=%h/%h exp=%h/%h",
                         c, got_a, got_b, mexp(0), mexp(1));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; div = 8'd1; mode = 2'b00;
        test_reset();
        test_lj();
        test_i2s();
        test_tdm();
        test_div_change();
        test_stop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
